// File: rtl/dma_ctrl.sv
// dma_ctrl: page-copy DMA engine snooping the MPU bus. A write to REG_ADDR
// stalls the MPU via RDY and copies 256 bytes from page $VV00-$VVFF to DST_ADDR.
// Ports:
//   CLK, RES                    clock, synchronous active-high reset
//   R_W, ABL, ABH, DB_OUT       MPU bus cycle (snooped and forwarded)
//   RDY                         MPU stall request (0 = stall next read)
//   MEM_DB_IN                   memory read data
//   MEM_R_W, MEM_ABL, MEM_ABH,
//   MEM_DB_OUT                  memory bus, muxed between MPU and DMA
//   BUSY, DONE                  status: engine active / one-cycle completion
module dma_ctrl #(
   parameter logic [15:0] REG_ADDR = 16'h4014,
   parameter logic [15:0] DST_ADDR = 16'h2004
) (
   input  logic       CLK,
   input  logic       RES,
   input  logic       R_W,
   input  logic [7:0] ABL,
   input  logic [7:0] ABH,
   input  logic [7:0] DB_OUT,
   output logic       RDY,
   input  logic [7:0] MEM_DB_IN,
   output logic       MEM_R_W,
   output logic [7:0] MEM_ABL,
   output logic [7:0] MEM_ABH,
   output logic [7:0] MEM_DB_OUT,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HALT  = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t     state, state_nx;
   logic [7:0] page, page_nx;
   logic [7:0] count, count_nx;
   logic [7:0] data, data_nx;
   logic       done_q, done_nx;
   logic       trig;

   assign trig = !R_W && ({ABH, ABL} == REG_ADDR);

   always_ff @(posedge CLK) begin
      if (RES) begin
         state  <= IDLE;
         page   <= 8'h00;
         count  <= 8'h00;
         data   <= 8'h00;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         page   <= page_nx;
         count  <= count_nx;
         data   <= data_nx;
         done_q <= done_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      page_nx    = page;
      count_nx   = count;
      data_nx    = data;
      done_nx    = 1'b0;
      RDY        = 1'b1;
      MEM_R_W    = R_W;
      MEM_ABL    = ABL;
      MEM_ABH    = ABH;
      MEM_DB_OUT = DB_OUT;
      unique case (state)
         IDLE: begin
            if (trig) begin
               page_nx  = DB_OUT;
               count_nx = 8'h00;
               state_nx = HALT;
            end
         end
         HALT: begin
            // MPU only freezes on a read; its writes keep passing through.
            RDY = 1'b0;
            if (R_W) begin
               state_nx = READ;
            end
         end
         READ: begin
            RDY        = 1'b0;
            MEM_R_W    = 1'b1;
            MEM_ABH    = page;
            MEM_ABL    = count;
            MEM_DB_OUT = 8'h00;
            data_nx    = MEM_DB_IN;
            state_nx   = WRITE;
         end
         WRITE: begin
            RDY        = 1'b0;
            MEM_R_W    = 1'b0;
            MEM_ABH    = DST_ADDR[15:8];
            MEM_ABL    = DST_ADDR[7:0];
            MEM_DB_OUT = data;
            if (count == 8'hFF) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               count_nx = count + 8'd1;
               state_nx = READ;
            end
         end
      endcase
   end

   assign BUSY = (state != IDLE);
   assign DONE = done_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed bench for dma_ctrl with a step-count transfer model
// compared every cycle, plus hand-computed per-scenario expectations.
module tb_dma_ctrl;

   localparam logic [15:0] DST = 16'h2004;
   localparam logic [15:0] REG = 16'h4014;

   logic       CLK = 1'b0;
   logic       RES = 1'b1;
   logic       R_W = 1'b1;
   logic [7:0] ABL = 8'h00;
   logic [7:0] ABH = 8'h00;
   logic [7:0] DB_OUT = 8'h00;
   logic       RDY;
   logic [7:0] MEM_DB_IN;
   logic       MEM_R_W;
   logic [7:0] MEM_ABL;
   logic [7:0] MEM_ABH;
   logic [7:0] MEM_DB_OUT;
   logic       BUSY;
   logic       DONE;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dma_ctrl dut (
      .CLK(CLK), .RES(RES), .R_W(R_W), .ABL(ABL), .ABH(ABH),
      .DB_OUT(DB_OUT), .RDY(RDY), .MEM_DB_IN(MEM_DB_IN),
      .MEM_R_W(MEM_R_W), .MEM_ABL(MEM_ABL), .MEM_ABH(MEM_ABH),
      .MEM_DB_OUT(MEM_DB_OUT), .BUSY(BUSY), .DONE(DONE)
   );

   // Memory image: page $03 holds i^$A5, other pages are salted by page.
   function automatic logic [7:0] mem_val(input logic [15:0] a);
      logic [7:0] salt;
      salt = (a[15:8] == 8'h03) ? 8'h00 : a[15:8];
      return a[7:0] ^ 8'hA5 ^ salt;
   endfunction

   assign MEM_DB_IN = mem_val({MEM_ABH, MEM_ABL});

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Transfer model: a transfer is 512 steps, even = read, odd = write.
   bit         valid = 0;
   bit         m_busy = 0;
   bit         m_halt = 0;
   bit         m_done = 0;
   int         m_step = 0;
   logic [7:0] m_page = 8'h00;

   // Per-scenario observations.
   int         cyc_n = 0;
   int         rdy_low = 0;
   int         n_wr = 0;
   logic [7:0] first_wd = 8'h00;
   logic [7:0] last_wd = 8'h00;
   bit         done_seen = 0;
   bit         zero_acc = 0;
   int         t_trig = 0;
   int         t_done = 0;

   always @(negedge CLK) begin
      logic       e_rw;
      logic [15:0] e_ab;
      logic [7:0] e_do;
      if (valid) begin
         e_rw = R_W;
         e_ab = {ABH, ABL};
         e_do = DB_OUT;
         if (m_busy && !m_halt) begin
            if (m_step % 2 == 0) begin
               e_rw = 1'b1;
               e_ab = {m_page, 8'(m_step / 2)};
               e_do = 8'h00;
            end else begin
               e_rw = 1'b0;
               e_ab = DST;
               e_do = mem_val({m_page, 8'(m_step / 2)});
            end
         end
         chk("rdy", RDY, !m_busy);
         chk("busy", BUSY, m_busy);
         chk("done", DONE, m_done);
         chk("mem_r_w", MEM_R_W, e_rw);
         chk("mem_ab", {MEM_ABH, MEM_ABL}, e_ab);
         chk("mem_db_out", MEM_DB_OUT, e_do);

         if (!RDY) rdy_low++;
         if (!MEM_R_W && {MEM_ABH, MEM_ABL} == DST) begin
            if (n_wr == 0) first_wd = MEM_DB_OUT;
            last_wd = MEM_DB_OUT;
            n_wr++;
         end
         if (BUSY && MEM_R_W && {MEM_ABH, MEM_ABL} == 16'h0000)
            zero_acc = 1;
         if (DONE) begin
            done_seen = 1;
            t_done = cyc_n;
         end
      end

      if (RES) begin
         m_busy = 0;
         m_done = 0;
         valid = 1;
      end else if (!m_busy) begin
         m_done = 0;
         if (!R_W && {ABH, ABL} == REG) begin
            m_busy = 1;
            m_halt = 1;
            m_page = DB_OUT;
            t_trig = cyc_n;
         end
      end else if (m_halt) begin
         m_done = 0;
         if (R_W) begin
            m_halt = 0;
            m_step = 0;
         end
      end else begin
         m_done = 0;
         if (m_step == 511) begin
            m_busy = 0;
            m_done = 1;
         end else begin
            m_step++;
         end
      end
      cyc_n++;
   end

   task automatic bus(input logic rw, input logic [15:0] a,
                      input logic [7:0] d);
      @(posedge CLK);
      #1;
      RES = 1'b0;
      R_W = rw;
      {ABH, ABL} = a;
      DB_OUT = d;
   endtask

   task automatic clr();
      rdy_low = 0;
      n_wr = 0;
      done_seen = 0;
      zero_acc = 0;
      first_wd = 8'h00;
      last_wd = 8'h00;
   endtask

   task automatic run_done(input string nm, input int budget);
      for (int i = 0; i < budget && !done_seen; i++)
         bus(1'b1, 16'h8000, 8'h00);
      chk(nm, done_seen, 1'b1);
      repeat (3) bus(1'b1, 16'h8000, 8'h00);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RES = 1'b0;
      chk("rst_rdy", RDY, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);

      // Plain transfer from page $03.
      clr();
      bus(1'b0, REG, 8'h03);
      run_done("t1_timeout", 600);
      chk("t1_stall", 16'(rdy_low), 16'd513);
      chk("t1_writes", 16'(n_wr), 16'd256);
      chk("t1_first", first_wd, 8'hA5);
      chk("t1_last", last_wd, 8'h5A);
      chk("t1_done_t", 16'(t_done - t_trig), 16'd514);

      // Two MPU writes during HALT delay the copy by two cycles.
      clr();
      bus(1'b0, REG, 8'h03);
      bus(1'b0, 16'h0123, 8'h11);
      bus(1'b0, 16'h0124, 8'h22);
      run_done("t2_timeout", 600);
      chk("t2_stall", 16'(rdy_low), 16'd515);
      chk("t2_writes", 16'(n_wr), 16'd256);
      chk("t2_done_t", 16'(t_done - t_trig), 16'd516);

      // Top page: must stop at $FFFF, never touch $0000.
      clr();
      bus(1'b0, REG, 8'hFF);
      run_done("t3_timeout", 600);
      repeat (5) bus(1'b1, 16'h8000, 8'h00);
      chk("t3_writes", 16'(n_wr), 16'd256);
      chk("t3_zero", zero_acc, 1'b0);
      chk("t3_first", first_wd, 8'h5A);
      chk("t3_last", last_wd, 8'hA5);

      // Reset in the WRITE of byte 100 (T+203).
      clr();
      bus(1'b0, REG, 8'h03);
      repeat (202) bus(1'b1, 16'h8000, 8'h00);
      bus(1'b1, 16'h8000, 8'h00);
      RES = 1'b1;
      chk("t4_wr100_rw", MEM_R_W, 1'b0);
      chk("t4_wr100_db", MEM_DB_OUT, 8'hC1);
      bus(1'b1, 16'h8000, 8'h00);
      chk("t4_rdy", RDY, 1'b1);
      chk("t4_busy", BUSY, 1'b0);
      chk("t4_nodone", DONE, 1'b0);
      repeat (4) bus(1'b1, 16'h8000, 8'h00);
      chk("t4_nopulse", done_seen, 1'b0);
      chk("t4_partial", 16'(n_wr), 16'd101);
      clr();
      bus(1'b0, REG, 8'h03);
      run_done("t4_timeout", 600);
      chk("t4_restart_first", first_wd, 8'hA5);
      chk("t4_restart_writes", 16'(n_wr), 16'd256);

      // Near-miss addresses never trigger.
      clr();
      bus(1'b0, 16'h4015, 8'h03);
      bus(1'b1, REG, 8'h00);
      bus(1'b0, 16'h4114, 8'h03);
      bus(1'b1, 16'h8000, 8'h00);
      bus(1'b1, 16'h8000, 8'h00);
      chk("t5_rdy_low", 16'(rdy_low), 16'd0);
      chk("t5_busy", BUSY, 1'b0);

      // Re-write of the trigger register during HALT is ignored.
      clr();
      bus(1'b0, REG, 8'h03);
      bus(1'b0, REG, 8'h07);
      run_done("t6_timeout", 600);
      chk("t6_first", first_wd, 8'hA5);
      chk("t6_last", last_wd, 8'h5A);
      chk("t6_stall", 16'(rdy_low), 16'd514);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Page-copy DMA engine on the memory bus directly downstream of the `mpu` core. It snoops MPU bus cycles, and a write to its trigger register starts a transfer. It then stalls the MPU through `RDY` and copies 256 bytes from page `V` (`$VV00-$VVFF`) to a fixed destination port, one read and one write per byte. All memory traffic, from the MPU or from the DMA, leaves through this block's `MEM_*` outputs. Memory read data is wired externally to both `mpu.DB_IN` and this block's `MEM_DB_IN`.

## Interface
Parameters:
- `REG_ADDR`, default 16'h4014: trigger register address (write-only, snooped).
- `DST_ADDR`, default 16'h2004: destination address written for every byte.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RES`  in  1  synchronous, active-high reset.
- `R_W`  in  1  MPU read/write (1 = read).
- `ABL`  in  8  MPU address low.
- `ABH`  in  8  MPU address high.
- `DB_OUT`  in  8  MPU write data.
- `RDY`  out  1  to MPU; 0 stalls the MPU on its next read cycle.
- `MEM_DB_IN`  in  8  memory read data.
- `MEM_R_W`  out  1  memory read/write.
- `MEM_ABL`  out  8  memory address low.
- `MEM_ABH`  out  8  memory address high.
- `MEM_DB_OUT`  out  8  memory write data.
- `BUSY`  out  1  high in any state other than IDLE.
- `DONE`  out  1  one-cycle pulse after the last byte is written.

## Operation
- State machine with four states: IDLE, HALT, READ, WRITE.
- Internal registers: `page[7:0]`, `count[7:0]`, `data[7:0]`.
- IDLE:
  - `MEM_*` mirror the MPU inputs combinationally. `RDY=1`.
  - When `R_W=0` and `{ABH,ABL}==REG_ADDR`: latch `page<=DB_OUT` and `count<=0`, then go to HALT.
  - The triggering write is also passed through to memory.
- HALT:
  - `RDY=0` and `MEM_*` still mirror the MPU.
  - The MPU honours `RDY` only on read cycles. If `R_W=0`, the write passes through and the FSM stays in HALT.
  - If `R_W=1`, the MPU is frozen for that cycle and the cycle is a harmless dummy read; go to READ.
  - Writes to `REG_ADDR` while in HALT are passed through but ignored (no re-latch).
- READ:
  - `RDY=0`, `MEM_R_W=1`, `MEM_ABH=page`, `MEM_ABL=count`, `MEM_DB_OUT=8'h00`.
  - `data<=MEM_DB_IN`; go to WRITE.
- WRITE:
  - `RDY=0`, `MEM_R_W=0`, `{MEM_ABH,MEM_ABL}=DST_ADDR`, `MEM_DB_OUT=data`.
  - If `count==8'hFF`: go to IDLE and pulse `DONE`. Otherwise `count<=count+1` (8-bit) and go to READ.
- MPU address and data inputs are ignored during READ and WRITE. The stalled MPU holds them, and they are not forwarded.
- `count` never wraps within a transfer; the `8'hFF` check terminates it first.
- `page==8'hFF` is legal and reads `$FF00-$FFFF`.
- Reset values: state IDLE, `RDY=1`, `BUSY=0`, `DONE=0`, `page=count=data=0`. `MEM_*` follow the MPU inputs.
- Reset during any state aborts the transfer. The next cycle is IDLE with `RDY=1`. `DONE` is not pulsed, and any partially copied bytes stay in memory.

## Timing
- `RDY`, `BUSY`, and `MEM_*` are combinational decodes of the registered state (and of MPU inputs in IDLE/HALT). There are no combinational paths from `MEM_DB_IN` to any output.
- Cycle numbering, for a trigger write in cycle T:
  - T+1 is HALT.
  - Each MPU write cycle in HALT adds one cycle.
  - With no extra writes, READ for byte k is at T+2+2k and WRITE at T+3+2k.
- Total stall is 513 cycles from T+1 to T+513. Last WRITE at T+513.
- `DONE=1` and `RDY=1` in T+514. The MPU resumes its pending read in T+514.
- `DONE` is registered and high for exactly one cycle.
- `data` is captured on the READ-cycle clock edge, so memory must present read data within the same cycle.

## Test plan
- Trigger write `$4014<=$03`, MPU next cycle is a read, memory `$0300+i = i^$A5`. Required: `RDY` low T+1..T+513; 256 writes to `$2004` with data `i^$A5` in order; `DONE` at T+514; `BUSY` falls the same cycle.
- Same trigger, MPU issues two write cycles in HALT (RMW-style). Required: both writes appear on `MEM_*` unchanged; first READ is delayed by 2 cycles; total stall is 515 cycles.
- `page=$FF`. Required: reads `$FF00..$FFFF`, then `count` stops. No access to `$0000` and no 257th byte.
- Assert `RES` at byte 100 in WRITE. Required: next cycle IDLE, `RDY=1`, `BUSY=0`, no `DONE`. A new trigger restarts at byte 0.
- Write to `$4015` and read from `$4014`. Required: no trigger; `RDY` stays 1; `MEM_*` equals the MPU bus every cycle.
- Second write to `$4014` during HALT with `$07` after trigger `$03`. Required: transfer uses page `$03`.
